// File: rtl/ysyx_23060240_lsu.sv
// ============================================================================
// ysyx_23060240_lsu : multi-cycle load/store unit between EXU and WBU.
// Optional feature macro: LSU_MISALIGN_CHECK_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_23060240_lsu #(
  parameter int TIMEOUT = 16,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_rd_en_i,
  input  logic             in_wr_en_i,
  input  logic [2:0]       in_rd_ctrl_i,
  input  logic [1:0]       in_wr_size_i,
  input  logic [31:0]      in_addr_i,
  input  logic [31:0]      in_wdata_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  output logic [3:0]       mem_wmask_o,
  input  logic             mem_ack_i,
  input  logic [31:0]      mem_rdata_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_rdata_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             out_err_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [1:0]       size_q, size_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             w_misalign;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load;
  logic [3:0]       w_mask;
  logic [31:0]      w_wdata;

`ifdef LSU_MISALIGN_CHECK_EN
  logic w_half_acc;
  logic w_word_acc;
  // A set wr_en makes the op a store, so size comes from wr_size then.
  assign w_half_acc = in_wr_en_i ? (in_wr_size_i == 2'b01)
                                 : (in_rd_ctrl_i == 3'b011 || in_rd_ctrl_i == 3'b100);
  assign w_word_acc = in_wr_en_i ? (in_wr_size_i == 2'b10) : (in_rd_ctrl_i == 3'b101);
  assign w_misalign = (w_half_acc & in_addr_i[0]) | (w_word_acc & (|in_addr_i[1:0]));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_byte = 8'(mem_rdata_i >> {addr_q[1:0], 3'b000});
  assign w_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

  always_comb begin
    w_load = 32'd0;
    case (ctrl_q)
      3'b001:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b010:  w_load = {24'd0, w_byte};
      3'b011:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {16'd0, w_half};
      3'b101:  w_load = mem_rdata_i;
      default: w_load = 32'd0;
    endcase
  end

  always_comb begin
    w_mask  = 4'b0000;
    w_wdata = wdata_q;
    case (size_q)
      2'b00: begin
        w_mask  = 4'b0001 << addr_q[1:0];
        w_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        w_mask  = addr_q[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wdata_q[15:0]}};
      end
      2'b10:   w_mask = 4'b1111;
      default: w_mask = 4'b0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    ctrl_d  = ctrl_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          we_d    = in_wr_en_i;
          ctrl_d  = in_rd_ctrl_i;
          size_d  = in_wr_size_i;
          addr_d  = in_addr_i;
          wdata_d = in_wdata_i;
          tag_d   = in_tag_i;
          cnt_d   = '0;
          rdata_d = 32'd0;
          err_d   = 1'b0;
          if (!in_rd_en_i && !in_wr_en_i) begin
            state_d = S_RESP;
          end else if (w_misalign) begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Ack has priority over a timeout expiring in the same cycle.
        if (mem_ack_i) begin
          rdata_d = we_q ? 32'd0 : w_load;
          state_d = S_RESP;
        end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      ctrl_q  <= 3'd0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      tag_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      ctrl_q  <= ctrl_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign mem_req_o   = (state_q == S_REQ);
  assign mem_we_o    = (state_q == S_REQ) & we_q;
  assign mem_addr_o  = {addr_q[31:2], 2'b00};
  assign mem_wdata_o = w_wdata;
  assign mem_wmask_o = ((state_q == S_REQ) && we_q) ? w_mask : 4'b0000;
  assign out_valid_o = (state_q == S_RESP);
  assign out_rdata_o = rdata_q;
  assign out_tag_o   = tag_q;
  assign out_err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060240_lsu.sv
// Self-checking bench for ysyx_23060240_lsu against a behavioural LSU model.
`default_nettype none

module tb_ysyx_23060240_lsu;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_rd_en = 1'b0;
  logic        in_wr_en = 1'b0;
  logic [2:0]  in_rd_ctrl = 3'd0;
  logic [1:0]  in_wr_size = 2'd0;
  logic [31:0] in_addr = 32'd0;
  logic [31:0] in_wdata = 32'd0;
  logic [4:0]  in_tag = 5'd0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rdata;
  logic [4:0]  out_tag;
  logic        out_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ysyx_23060240_lsu #(.TIMEOUT(TO), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_rd_en_i(in_rd_en), .in_wr_en_i(in_wr_en),
    .in_rd_ctrl_i(in_rd_ctrl), .in_wr_size_i(in_wr_size),
    .in_addr_i(in_addr), .in_wdata_i(in_wdata), .in_tag_i(in_tag),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_rdata_o(out_rdata), .out_tag_o(out_tag), .out_err_o(out_err)
  );

  // Issue one op, play memory (ack after ack_dly REQ cycles, or never if < 0),
  // hold out_ready low for hold cycles, and check everything against the model.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] ctrl,
                        input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] tag,
                        input int ack_dly, input logic [31:0] rdata,
                        input int hold, input string name);
    logic is_mem, misal, half_acc, word_acc;
    logic [31:0] e_wdata, e_rdata, bytev, halfv;
    logic [3:0] e_mask;
    logic e_err;
    int n, e_cycles;
    is_mem   = rd | wr;
    half_acc = wr ? (size == 2'd1) : (ctrl == 3'd3 || ctrl == 3'd4);
    word_acc = wr ? (size == 2'd2) : (ctrl == 3'd5);
    misal = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    misal = (half_acc && (addr % 2 != 0)) || (word_acc && (addr % 4 != 0));
`endif
    e_mask = 4'd0;
    e_wdata = wd;
    case (size)
      2'd0: begin e_mask = 4'(1 << (addr % 4)); e_wdata = (wd % 256) * 32'h0101_0101; end
      2'd1: begin e_mask = 4'(3 << (2 * ((addr / 2) % 2))); e_wdata = (wd % 65536) * 32'h0001_0001; end
      2'd2: e_mask = 4'hf;
      default: e_mask = 4'd0;
    endcase
    bytev = (rdata >> (8 * (addr % 4))) % 256;
    halfv = ((addr / 2) % 2 == 1) ? (rdata >> 16) : (rdata % 65536);
    case (ctrl)
      3'd1: e_rdata = (bytev >= 128) ? bytev + 32'hFFFF_FF00 : bytev;
      3'd2: e_rdata = bytev;
      3'd3: e_rdata = (halfv >= 32768) ? halfv + 32'hFFFF_0000 : halfv;
      3'd4: e_rdata = halfv;
      3'd5: e_rdata = rdata;
      default: e_rdata = 32'd0;
    endcase
    e_err = 1'b0;
    if (!is_mem) e_rdata = 32'd0;
    else if (misal) begin e_rdata = 32'd0; e_err = 1'b1; end
    else if (ack_dly < 0) begin e_rdata = 32'd0; e_err = 1'b1; end
    else if (wr) e_rdata = 32'd0;

    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL %s accept_ready got=%b exp=1", name, in_ready); end
    in_valid = 1'b1; in_rd_en = rd; in_wr_en = wr; in_rd_ctrl = ctrl;
    in_wr_size = size; in_addr = addr; in_wdata = wd; in_tag = tag;
    @(negedge clk);
    in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom; in_tag = 5'($urandom);

    if (!is_mem || misal) begin
      total++;
      if (mem_req !== 1'b0) begin bad++; $display("FAIL %s no_req got=%b exp=0", name, mem_req); end
    end else begin
      n = 0;
      e_cycles = (ack_dly >= 0) ? ack_dly + 1 : TO;
      while (mem_req === 1'b1 && n < 64) begin
        total++;
        if (mem_addr !== {addr[31:2], 2'b00}) begin bad++; $display("FAIL %s mem_addr got=%h exp=%h", name, mem_addr, {addr[31:2], 2'b00}); end
        total++;
        if (mem_we !== wr) begin bad++; $display("FAIL %s mem_we got=%b exp=%b", name, mem_we, wr); end
        total++;
        if (mem_wmask !== (wr ? e_mask : 4'd0)) begin bad++; $display("FAIL %s mem_wmask got=%b exp=%b", name, mem_wmask, wr ? e_mask : 4'd0); end
        if (wr && size != 2'd3) begin
          total++;
          if (mem_wdata !== e_wdata) begin bad++; $display("FAIL %s mem_wdata got=%h exp=%h", name, mem_wdata, e_wdata); end
        end
        if (n == ack_dly) begin mem_ack = 1'b1; mem_rdata = rdata; end
        else mem_rdata = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        n++;
      end
      total++;
      if (n != e_cycles) begin bad++; $display("FAIL %s req_cycles got=%0d exp=%0d", name, n, e_cycles); end
    end

    for (int h = 0; h <= hold; h++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL %s resp_hs got=%b/%b exp=1/0", name, out_valid, in_ready);
      end
      total++;
      if (out_rdata !== e_rdata) begin bad++; $display("FAIL %s out_rdata got=%h exp=%h", name, out_rdata, e_rdata); end
      total++;
      if (out_tag !== tag || out_err !== e_err) begin
        bad++; $display("FAIL %s tag_err got=%h/%b exp=%h/%b", name, out_tag, out_err, tag, e_err);
      end
      if (h < hold) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL %s release got=%b/%b exp=0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_wmask !== 4'd0) begin
      bad++; $display("FAIL reset_mem got=%b%b%b%b exp=1000", in_ready, mem_req, mem_we, mem_wmask);
    end
    total++;
    if (out_valid !== 1'b0 || out_err !== 1'b0 || out_rdata !== 32'd0 || out_tag !== 5'd0) begin
      bad++; $display("FAIL reset_out got=%b %b %h %h exp=0 0 0 0", out_valid, out_err, out_rdata, out_tag);
    end
  endtask

  task automatic test_directed();
    run_op(1, 0, 3'd1, 2'd0, 32'h8000_0003, 32'h0, 5'd7, 0, 32'h80FF_1234, 0, "lb_sext");
    run_op(0, 1, 3'd0, 2'd1, 32'h8000_0006, 32'h0000_BEEF, 5'd9, 2, 32'h0, 0, "sh_upper");
    run_op(0, 1, 3'd0, 2'd0, 32'h1000_0001, 32'h1234_56A5, 5'd3, 1, 32'h0, 0, "sb_lane1");
    run_op(1, 1, 3'd5, 2'd2, 32'h2000_0010, 32'hCAFE_F00D, 5'd4, 0, 32'h0, 0, "both_store");
    run_op(0, 0, 3'd5, 2'd2, 32'h2000_0010, 32'h1, 5'd21, 0, 32'h0, 0, "no_op");
    run_op(1, 0, 3'd3, 2'd0, 32'h0000_0002, 32'h0, 5'd1, 3, 32'h8001_7FFF, 0, "lh_hi");
  endtask

  task automatic test_timeout();
    run_op(1, 0, 3'd5, 2'd0, 32'h8000_0100, 32'h0, 5'd12, -1, 32'h0, 0, "lw_timeout");
  endtask

  task automatic test_backpressure();
    run_op(1, 0, 3'd5, 2'd0, 32'h8000_0040, 32'h0, 5'd30, 1, 32'hDEAD_BEEF, 5, "bp_lw");
  endtask

  task automatic test_misalign();
    run_op(1, 0, 3'd4, 2'd0, 32'h8000_0001, 32'h0, 5'd5, 0, 32'hABCD_9876, 0, "lhu_odd");
    run_op(1, 0, 3'd5, 2'd0, 32'h8000_0003, 32'h0, 5'd6, 1, 32'h1357_2468, 0, "lw_mis");
    run_op(0, 1, 3'd0, 2'd2, 32'h8000_0002, 32'h1111_2222, 5'd8, 0, 32'h0, 0, "sw_mis");
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    in_valid = 1'b1; in_rd_en = 1'b1; in_wr_en = 1'b0; in_rd_ctrl = 3'd5; in_addr = 32'h8000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_mid pre_req got=%b exp=1", mem_req); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (mem_req !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid after got=%b%b%b exp=010", mem_req, in_ready, out_valid);
    end
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid late_ack got=%b%b exp=01", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = int'($urandom % 4);
      run_op(kind == 1 || kind == 3, kind >= 2, 3'($urandom), 2'($urandom), $urandom, $urandom,
             5'($urandom), int'($urandom % 4), $urandom, int'($urandom % 3), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_backpressure();
    test_misalign();
    test_reset_midop();
    test_random();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

`default_nettype wire
